load_store_unit: RTL and testbench

- Memory/writeback stage directly downstream of the execute stage.
- Consumes the execute result bundle and either registers ALU results for register-file writeback, or performs a load/store over a req/ack data-memory port.
- Handles byte/halfword/word sizing, load sign/zero extension and store byte strobes.
- Stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/load_store_unit.sv | 203 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory/writeback stage: registers ALU results for writeback, or runs a
// single load/store over a req/ack data-memory port while stalling upstream.
module load_store_unit #(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic            i_is_reg_write,
    input  logic            i_is_mem_read,
    input  logic            i_is_mem_write,
    input  logic [XLEN-1:0] i_mem_address,
    input  logic [2:0]      i_mem_size,
    input  logic [4:0]      i_rd_id,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic [XLEN-1:0] i_reg_data,
    output logic            o_stall,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [3:0]      o_mem_wstrb,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic            i_mem_ack,
    output logic            o_rd_wr_en,
    output logic [4:0]      o_rd_id,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_misaligned,
    output logic            o_mem_fault
);

    typedef enum logic { IDLE, WAIT_ACK } state_t;
    typedef enum logic [1:0] { SZ_B, SZ_H, SZ_W } size_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] wait_cnt;
    logic        lat_load;
    logic [2:0]  lat_size;
    logic [1:0]  lat_off;
    logic [4:0]  lat_rd;

    logic        is_mem;
    logic        aligned;
    logic        issue;
    logic        timeout_hit;

    // Reserved funct3 encodings fall through to word accesses.
    function automatic size_t size_decode(input logic [2:0] size);
        case (size)
            3'b000, 3'b100: size_decode = SZ_B;
            3'b001, 3'b101: size_decode = SZ_H;
            default:        size_decode = SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [2:0] size, input logic [1:0] off);
        case (size_decode(size))
            SZ_B:    store_wstrb = 4'b0001 << off;
            SZ_H:    store_wstrb = 4'b0011 << off;
            default: store_wstrb = 4'b1111;
        endcase
    endfunction

    // Narrow stores are replicated across every lane; the strobe picks the live one.
    function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] size, input logic [XLEN-1:0] data);
        case (size_decode(size))
            SZ_B:    store_wdata = {4{data[7:0]}};
            SZ_H:    store_wdata = {2{data[15:0]}};
            default: store_wdata = data;
        endcase
    endfunction

    // Selects the addressed byte/half of the read word and extends it; the
    // top funct3 bit marks the unsigned variants.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                    input logic [2:0]      size,
                                                    input logic [1:0]      off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (size_decode(size))
            SZ_B:    load_extend = size[2] ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
            SZ_H:    load_extend = size[2] ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // Request qualification and timeout detection for the current cycle.
    always_comb begin
        is_mem = i_is_mem_read | i_is_mem_write;
        case (size_decode(i_mem_size))
            SZ_B:    aligned = 1'b1;
            SZ_H:    aligned = ~i_mem_address[0];
            default: aligned = (i_mem_address[1:0] == 2'b00);
        endcase
        issue       = (state == IDLE) && i_valid && is_mem && aligned;
        timeout_hit = (ACK_TIMEOUT != 0) && !i_mem_ack &&
                      (wait_cnt == 32'(ACK_TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state and stall; stall releases in the ack/timeout cycle so the
    // upstream bundle advances exactly once per memory access.
    always_comb begin
        state_next = state;
        o_stall    = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next = WAIT_ACK;
                    o_stall    = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (i_mem_ack || timeout_hit) state_next = IDLE;
                else                          o_stall    = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory request, latched access attributes, writeback and event pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_wstrb  <= 4'b0000;
            o_rd_wr_en   <= 1'b0;
            o_rd_id      <= 5'd0;
            o_rd_data    <= '0;
            o_misaligned <= 1'b0;
            o_mem_fault  <= 1'b0;
            wait_cnt     <= 32'd0;
            lat_load     <= 1'b0;
            lat_size     <= 3'b000;
            lat_off      <= 2'b00;
            lat_rd       <= 5'd0;
        end else begin
            o_rd_wr_en   <= 1'b0;
            o_misaligned <= 1'b0;
            o_mem_fault  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid && !is_mem) begin
                        if (i_is_reg_write && (i_rd_id != 5'd0)) begin
                            o_rd_wr_en <= 1'b1;
                            o_rd_id    <= i_rd_id;
                            o_rd_data  <= i_reg_data;
                        end
                    end else if (i_valid && !aligned) begin
                        o_misaligned <= 1'b1;
                    end else if (issue) begin
                        // A read+write bundle is treated as a load.
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= ~i_is_mem_read;
                        o_mem_addr  <= {i_mem_address[XLEN-1:2], 2'b00};
                        o_mem_wdata <= i_is_mem_read ? '0 : store_wdata(i_mem_size, i_mem_data);
                        o_mem_wstrb <= i_is_mem_read ? 4'b0000
                                                     : store_wstrb(i_mem_size, i_mem_address[1:0]);
                        lat_load    <= i_is_mem_read;
                        lat_size    <= i_mem_size;
                        lat_off     <= i_mem_address[1:0];
                        lat_rd      <= i_rd_id;
                        wait_cnt    <= 32'd0;
                    end
                end
                WAIT_ACK: begin
                    if (i_mem_ack) begin
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_wstrb <= 4'b0000;
                        wait_cnt    <= 32'd0;
                        if (lat_load && (lat_rd != 5'd0)) begin
                            o_rd_wr_en <= 1'b1;
                            o_rd_id    <= lat_rd;
                            o_rd_data  <= load_extend(i_mem_rdata, lat_size, lat_off);
                        end
                    end else if (timeout_hit) begin
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_wstrb <= 4'b0000;
                        o_mem_fault <= 1'b1;
                        wait_cnt    <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected writebacks
// and memory requests into queues; a negedge monitor pops and compares them.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_is_reg_write, i_is_mem_read, i_is_mem_write;
    logic [31:0] i_mem_address, i_mem_data, i_reg_data, i_mem_rdata;
    logic [2:0]  i_mem_size;
    logic [4:0]  i_rd_id;
    logic        i_mem_ack;
    logic        o_stall, o_mem_req, o_mem_we, o_rd_wr_en, o_misaligned, o_mem_fault;
    logic [31:0] o_mem_addr, o_mem_wdata, o_rd_data;
    logic [3:0]  o_mem_wstrb;
    logic [4:0]  o_rd_id;

    int pass_cnt = 0;
    int total    = 0;

    logic [4:0]  wb_rd_q[$];
    logic [31:0] wb_data_q[$];
    logic [31:0] rq_addr_q[$];
    logic        rq_we_q[$];
    logic [3:0]  rq_strb_q[$];
    logic [31:0] rq_wdata_q[$];
    logic        req_prev = 1'b0;

    load_store_unit #(.XLEN(32), .ACK_TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(i_valid), .i_is_reg_write(i_is_reg_write),
        .i_is_mem_read(i_is_mem_read), .i_is_mem_write(i_is_mem_write),
        .i_mem_address(i_mem_address), .i_mem_size(i_mem_size),
        .i_rd_id(i_rd_id), .i_mem_data(i_mem_data), .i_reg_data(i_reg_data),
        .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
        .o_rd_wr_en(o_rd_wr_en), .o_rd_id(o_rd_id), .o_rd_data(o_rd_data),
        .o_misaligned(o_misaligned), .o_mem_fault(o_mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    endtask

    // Monitor: writebacks and rising memory requests against the queues.
    always @(negedge clk) begin
        if (o_rd_wr_en === 1'b1) begin
            if (wb_rd_q.size() == 0) begin
                chk("wb_unexpected", 32'(o_rd_wr_en), 32'd0);
            end else begin
                chk("wb_rd", 32'(o_rd_id), 32'(wb_rd_q.pop_front()));
                chk("wb_data", o_rd_data, wb_data_q.pop_front());
            end
        end
        if (o_mem_req === 1'b1 && !req_prev) begin
            if (rq_addr_q.size() == 0) begin
                chk("req_unexpected", 32'(o_mem_req), 32'd0);
            end else begin
                logic we_e;
                chk("req_addr", o_mem_addr, rq_addr_q.pop_front());
                we_e = rq_we_q.pop_front();
                chk("req_we", 32'(o_mem_we), 32'(we_e));
                chk("req_wstrb", 32'(o_mem_wstrb), 32'(rq_strb_q.pop_front()));
                if (we_e) chk("req_wdata", o_mem_wdata, rq_wdata_q.pop_front());
                else      void'(rq_wdata_q.pop_front());
            end
        end
        req_prev = (o_mem_req === 1'b1);
    end

    task automatic idle_inputs();
        i_valid = 0; i_is_reg_write = 0; i_is_mem_read = 0; i_is_mem_write = 0;
        i_mem_address = 0; i_mem_size = 0; i_rd_id = 0; i_mem_data = 0; i_reg_data = 0;
    endtask

    task automatic alu_write(input logic [4:0] rd, input logic [31:0] data);
        @(posedge clk); #1;
        i_valid = 1; i_is_reg_write = 1; i_rd_id = rd; i_reg_data = data;
        if (rd != 0) begin wb_rd_q.push_back(rd); wb_data_q.push_back(data); end
        #1 chk("alu_stall", 32'(o_stall), 32'd0);
        @(posedge clk); #1 idle_inputs();
    endtask

    task automatic push_req(input logic [31:0] addr, input logic we, input logic [3:0] strb,
                            input logic [31:0] wdata);
        rq_addr_q.push_back(addr); rq_we_q.push_back(we);
        rq_strb_q.push_back(strb); rq_wdata_q.push_back(wdata);
    endtask

    // Presents an aligned access for one cycle; leaves the bench in the first WAIT_ACK cycle.
    task automatic mem_issue(input logic rd_f, input logic wr_f, input logic [31:0] addr,
                             input logic [2:0] size, input logic [31:0] data, input logic [4:0] rd);
        @(posedge clk); #1;
        i_valid = 1; i_is_mem_read = rd_f; i_is_mem_write = wr_f; i_is_reg_write = rd_f;
        i_mem_address = addr; i_mem_size = size; i_mem_data = data; i_rd_id = rd;
        #1 chk("issue_stall", 32'(o_stall), 32'd1);
        @(posedge clk); #1 idle_inputs();
    endtask

    task automatic mem_finish(input int n, input logic [31:0] rdata, input logic exp_wb);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("wait_stall", 32'(o_stall), 32'd1);
            chk("wait_req", 32'(o_mem_req), 32'd1);
            @(posedge clk); #1;
        end
        i_mem_ack = 1; i_mem_rdata = rdata;
        #1 chk("ack_stall", 32'(o_stall), 32'd0);
        @(posedge clk); #1;
        i_mem_ack = 0; i_mem_rdata = 0;
        @(negedge clk);
        chk("post_ack_req", 32'(o_mem_req), 32'd0);
        chk("post_ack_wb", 32'(o_rd_wr_en), 32'(exp_wb));
    endtask

    task automatic load(input logic [31:0] addr, input logic [2:0] size, input logic [4:0] rd,
                        input int n, input logic [31:0] rdata, input logic [31:0] exp);
        push_req({addr[31:2], 2'b00}, 1'b0, 4'b0000, 32'd0);
        if (rd != 0) begin wb_rd_q.push_back(rd); wb_data_q.push_back(exp); end
        mem_issue(1'b1, 1'b0, addr, size, 32'd0, rd);
        mem_finish(n, rdata, rd != 0);
    endtask

    task automatic store(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                         input int n, input logic [3:0] strb, input logic [31:0] wdata);
        push_req({addr[31:2], 2'b00}, 1'b1, strb, wdata);
        mem_issue(1'b0, 1'b1, addr, size, data, 5'd6);
        mem_finish(n, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic misaligned(input logic [31:0] addr, input logic [2:0] size, input logic wr_f);
        @(posedge clk); #1;
        i_valid = 1; i_is_mem_read = ~wr_f; i_is_mem_write = wr_f; i_is_reg_write = ~wr_f;
        i_mem_address = addr; i_mem_size = size; i_rd_id = 5'd4; i_mem_data = 32'h1357_9BDF;
        #1 chk("mis_stall", 32'(o_stall), 32'd0);
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        chk("mis_pulse", 32'(o_misaligned), 32'd1);
        chk("mis_req", 32'(o_mem_req), 32'd0);
        chk("mis_wb", 32'(o_rd_wr_en), 32'd0);
        @(negedge clk);
        chk("mis_pulse_end", 32'(o_misaligned), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        i_mem_ack = 0; i_mem_rdata = 0;
        rst_n = 0;
        #1;
        chk("rst_req", 32'(o_mem_req), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_wb", {26'd0, o_rd_wr_en, o_rd_id}, 32'd0);
        chk("rst_data", o_rd_data, 32'd0);
        chk("rst_pulses", {30'd0, o_misaligned, o_mem_fault}, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1;

        // ALU writeback, plus rd=0 which must not write.
        alu_write(5'd5, 32'h0000_1234);
        alu_write(5'd0, 32'hDEAD_0000);

        // Loads: sign/zero extension across lanes and sizes.
        load(32'h0000_0103, 3'b000, 5'd10, 2, 32'h80FF_FF7F, 32'hFFFF_FF80);
        load(32'h0000_0103, 3'b100, 5'd11, 2, 32'h80FF_FF7F, 32'h0000_0080);
        load(32'h0000_0101, 3'b000, 5'd12, 0, 32'h80FF_FF7F, 32'hFFFF_FFFF);
        load(32'h0000_0102, 3'b001, 5'd13, 1, 32'h8001_1234, 32'hFFFF_8001);
        load(32'h0000_0102, 3'b101, 5'd14, 1, 32'h8001_1234, 32'h0000_8001);
        load(32'h0000_0200, 3'b010, 5'd15, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load(32'h0000_0204, 3'b111, 5'd16, 1, 32'h0BAD_F00D, 32'h0BAD_F00D);
        load(32'h0000_0300, 3'b010, 5'd0,  1, 32'h1111_2222, 32'h0);

        // Read and write together behaves as a load.
        push_req(32'h0000_0040, 1'b0, 4'b0000, 32'd0);
        wb_rd_q.push_back(5'd17); wb_data_q.push_back(32'h0000_00A5);
        mem_issue(1'b1, 1'b1, 32'h0000_0040, 3'b100, 32'h7777_7777, 5'd17);
        mem_finish(0, 32'h0000_00A5, 1'b1);

        // Stores: strobes and lane replication.
        store(32'h0000_0022, 3'b001, 32'hABCD_BEEF, 1, 4'b1100, 32'hBEEF_BEEF);
        store(32'h0000_0041, 3'b000, 32'h1234_565A, 0, 4'b0010, 32'h5A5A_5A5A);
        store(32'h0000_0080, 3'b010, 32'h1122_3344, 2, 4'b1111, 32'h1122_3344);

        // Misaligned accesses.
        misaligned(32'h0000_0102, 3'b010, 1'b0);
        misaligned(32'h0000_0021, 3'b001, 1'b1);

        // Timeout after four ack-less WAIT_ACK cycles.
        push_req(32'h0000_0300, 1'b0, 4'b0000, 32'd0);
        mem_issue(1'b1, 1'b0, 32'h0000_0300, 3'b010, 32'd0, 5'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("to_wait_stall", 32'(o_stall), 32'd1);
            chk("to_wait_fault", 32'(o_mem_fault), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_hit_stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        chk("to_fault", 32'(o_mem_fault), 32'd1);
        chk("to_req", 32'(o_mem_req), 32'd0);
        chk("to_stall", 32'(o_stall), 32'd0);
        chk("to_wb", 32'(o_rd_wr_en), 32'd0);
        @(negedge clk);
        chk("to_fault_end", 32'(o_mem_fault), 32'd0);
        @(posedge clk); #1 i_mem_ack = 1; i_mem_rdata = 32'hCCCC_CCCC;
        @(posedge clk); #1 i_mem_ack = 0;
        @(negedge clk);
        chk("stray_ack_wb", 32'(o_rd_wr_en), 32'd0);
        chk("stray_ack_req", 32'(o_mem_req), 32'd0);

        // Reset while waiting for an ack.
        push_req(32'h0000_0010, 1'b1, 4'b1111, 32'h5555_AAAA);
        mem_issue(1'b0, 1'b1, 32'h0000_0010, 3'b010, 32'h5555_AAAA, 5'd9);
        @(negedge clk);
        chk("rw_stall", 32'(o_stall), 32'd1);
        @(posedge clk); #1 rst_n = 0;
        #1;
        chk("rw_req", 32'(o_mem_req), 32'd0);
        chk("rw_we_strb", {27'd0, o_mem_we, o_mem_wstrb}, 32'd0);
        chk("rw_addr", o_mem_addr, 32'd0);
        chk("rw_wdata", o_mem_wdata, 32'd0);
        chk("rw_stall0", 32'(o_stall), 32'd0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1 i_mem_ack = 1; i_mem_rdata = 32'h9999_9999;
        #1 chk("rw_ack_stall", 32'(o_stall), 32'd0);
        @(posedge clk); #1 i_mem_ack = 0;
        @(negedge clk);
        chk("rw_post_wb", 32'(o_rd_wr_en), 32'd0);
        chk("rw_post_req", 32'(o_mem_req), 32'd0);
        alu_write(5'd3, 32'h0000_CAFE);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wb_queue_empty", 32'(wb_rd_q.size()), 32'd0);
        chk("req_queue_empty", 32'(rq_addr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
